golden_nonce_scan: RTL and testbench

GOLDEN_NONCE_SCAN -- requirements
Module: golden_nonce_scan

---
 rtl/golden_nonce_scan.sv | 147 ++++++++++++++
 tb/tb_golden_nonce_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_scan.sv
// Scans NUM_NONCES hash words for the minimum and optionally writes it back.
// Define GOLDEN_NONCE_WRITEBACK_EN to enable the two-word result write.
module golden_nonce_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] input_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [15:0] best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

`ifdef GOLDEN_NONCE_WRITEBACK_EN
  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, WRITE0, WRITE1, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;
`endif

  localparam logic [15:0] LAST = 16'(NUM_NONCES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [15:0] addr_q;
  logic [31:0] tgt_q;
  logic [15:0] widx;
  logic        take;
  logic [31:0] nxt_hash;
  logic [15:0] nxt_nonce;

  assign mem_clk  = clk;
  assign mem_addr = addr_q;

`ifdef GOLDEN_NONCE_WRITEBACK_EN
  logic        we_q;
  logic [31:0] wdata_q;
  logic [15:0] raddr_q;
  assign mem_we         = we_q;
  assign mem_write_data = wdata_q;
`else
  logic unused_result_addr;
  assign unused_result_addr = ^result_addr;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;
`endif

  // Candidate update for the word arriving this cycle
  always_comb begin
    widx      = (state_q == DRAIN) ? cnt_q : cnt_q - 16'd1;
    take      = (widx == 16'd0) || (mem_read_data < best_hash);
    nxt_hash  = take ? mem_read_data : best_hash;
    nxt_nonce = take ? widx : best_nonce;
  end

  // Scan FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      done       <= 1'b0;
      found      <= 1'b0;
      best_nonce <= 16'd0;
      best_hash  <= 32'hFFFF_FFFF;
      cnt_q      <= 16'd0;
      addr_q     <= 16'd0;
      tgt_q      <= 32'd0;
`ifdef GOLDEN_NONCE_WRITEBACK_EN
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      raddr_q    <= 16'd0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q     <= input_addr;
            tgt_q      <= target;
            cnt_q      <= 16'd0;
            found      <= 1'b0;
            best_hash  <= 32'hFFFF_FFFF;
            best_nonce <= 16'd0;
`ifdef GOLDEN_NONCE_WRITEBACK_EN
            raddr_q    <= result_addr;
`endif
            state_q    <= READ;
          end
        end
        READ: begin
          if (cnt_q != 16'd0) begin
            best_hash  <= nxt_hash;
            best_nonce <= nxt_nonce;
          end
          if (cnt_q == LAST) begin
            state_q <= DRAIN;
          end else begin
            cnt_q  <= cnt_q + 16'd1;
            addr_q <= addr_q + 16'd1;
          end
        end
        DRAIN: begin
          best_hash  <= nxt_hash;
          best_nonce <= nxt_nonce;
          found      <= (nxt_hash < tgt_q);
`ifdef GOLDEN_NONCE_WRITEBACK_EN
          we_q       <= 1'b1;
          addr_q     <= raddr_q;
          wdata_q    <= nxt_hash;
          state_q    <= WRITE0;
`else
          done       <= 1'b1;
          state_q    <= DONE;
`endif
        end
`ifdef GOLDEN_NONCE_WRITEBACK_EN
        WRITE0: begin
          addr_q  <= raddr_q + 16'd1;
          wdata_q <= {found, 15'd0, best_nonce};
          state_q <= WRITE1;
        end
        WRITE1: begin
          we_q    <= 1'b0;
          done    <= 1'b1;
          state_q <= DONE;
        end
`endif
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golden_nonce_scan.sv
// Self-checking bench for golden_nonce_scan.
// Works with or without GOLDEN_NONCE_WRITEBACK_EN.
module tb_golden_nonce_scan;
  localparam int N = 16;
`ifdef GOLDEN_NONCE_WRITEBACK_EN
  localparam int DLAT = N + 4;
`else
  localparam int DLAT = N + 2;
`endif

  logic        clk = 0;
  logic        reset_n;
  logic        start;
  logic [15:0] input_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [15:0] best_nonce;
  logic [31:0] best_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  golden_nonce_scan #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .input_addr(input_addr), .result_addr(result_addr),
    .target(target), .done(done), .found(found),
    .best_nonce(best_nonce), .best_hash(best_hash),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [47:0] wq [$];

  always @(posedge clk) mem_read_data <= mem[mem_addr];
  always @(posedge clk) if (mem_we) wq.push_back({mem_addr, mem_write_data});

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference: minimum of the word list, first occurrence wins ties
  task automatic model(input logic [15:0] base, input logic [31:0] tgt,
                       output logic [15:0] bn, output logic [31:0] bh,
                       output logic f);
    int unsigned q[$];
    int unsigned mn[$];
    int idx[$];
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = base + 16'(i);
      q.push_back(mem[a]);
    end
    mn  = q.min();
    idx = q.find_first_index(x) with (x == mn[0]);
    bh  = mn[0];
    bn  = 16'(idx[0]);
    f   = (bh < tgt);
  endtask

  task automatic run_scan(input string tag, input logic [15:0] base,
                          input logic [15:0] raddr,
                          input logic [31:0] tgt);
    logic [15:0] ebn;
    logic [31:0] ebh;
    logic        ef;
    int          cyc;
    logic        addr_ok;
    model(base, tgt, ebn, ebh, ef);
    wq.delete();
    @(negedge clk);
    input_addr  = base;
    result_addr = raddr;
    target      = tgt;
    start       = 1;
    @(posedge clk); #1;
    start   = 0;
    cyc     = 1;
    addr_ok = 1;
    while (!done && cyc < 200) begin
      if (cyc <= N && mem_addr !== base + 16'(cyc - 1)) addr_ok = 0;
      if (cyc <= N && mem_we) addr_ok = 0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done_cycle"}, 64'(cyc), 64'(DLAT));
    chk({tag, " read_addr"}, 64'(addr_ok), 64'd1);
    chk({tag, " best_nonce"}, 64'(best_nonce), 64'(ebn));
    chk({tag, " best_hash"}, 64'(best_hash), 64'(ebh));
    chk({tag, " found"}, 64'(found), 64'(ef));
`ifdef GOLDEN_NONCE_WRITEBACK_EN
    chk({tag, " wr_count"}, 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk({tag, " wr0"}, 64'(wq[0]), 64'({raddr, ebh}));
      chk({tag, " wr1"}, 64'(wq[1]),
          64'({raddr + 16'd1, ef, 15'd0, ebn}));
    end
`else
    chk({tag, " wr_count"}, 64'(wq.size()), 64'd0);
`endif
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [15:0] ebn;
    logic [31:0] ebh;
    logic        ef;
    logic [15:0] a;
    int          ndone;
    int          bad;
    int          scans;
    reset_n     = 0;
    start       = 0;
    input_addr  = 0;
    result_addr = 0;
    target      = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", 64'(done), 64'd0);
    chk("rst found", 64'(found), 64'd0);
    chk("rst nonce", 64'(best_nonce), 64'd0);
    chk("rst hash", 64'(best_hash), 64'hFFFF_FFFF);
    chk("rst we", 64'(mem_we), 64'd0);
    @(negedge clk);
    reset_n = 1;

    // Ascending words, clear winner at index 0
    for (int i = 0; i < N; i++) mem[16'h0100 + i] = 32'h1000_0000 + i;
    run_scan("asc", 16'h0100, 16'h0200, 32'h2000_0000);

    // Tie at words 9 and 12, target equal to minimum
    for (int i = 0; i < N; i++) mem[16'h0300 + i] = 32'hFFFF_FFFF;
    mem[16'h0309] = 5;
    mem[16'h030C] = 5;
    run_scan("tie", 16'h0300, 16'h0400, 32'd5);

    // Address wrap across 0xFFFF
    for (int i = 0; i < N; i++) begin
      a = 16'hFFF8 + 16'(i);
      mem[a] = $urandom;
    end
    run_scan("wrap", 16'hFFF8, 16'hFFFF, 32'h8000_0000);

    // Random scans with narrow value ranges to provoke ties
    for (int t = 0; t < 5; t++) begin
      a = 16'($urandom_range(16'h1000, 16'hE000));
      for (int i = 0; i < N; i++) mem[a + 16'(i)] = $urandom_range(0, 12);
      run_scan("rand", a, 16'($urandom), $urandom_range(0, 14));
    end

    // Target zero never finds
    for (int i = 0; i < N; i++) mem[16'h0500 + i] = $urandom_range(0, 3);
    run_scan("tgt0", 16'h0500, 16'h0600, 32'd0);

    // Reset in READ cycle 7
    for (int i = 0; i < N; i++) mem[16'h0700 + i] = 32'd100 + i;
    @(negedge clk);
    input_addr  = 16'h0700;
    result_addr = 16'h0800;
    target      = 32'hFFFF_FFFF;
    start       = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 0;
    @(posedge clk); #1;
    chk("midrst hash", 64'(best_hash), 64'hFFFF_FFFF);
    chk("midrst nonce", 64'(best_nonce), 64'd0);
    chk("midrst we", 64'(mem_we), 64'd0);
    reset_n = 1;
    wq.delete();
    ndone = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst no_done", 64'(ndone), 64'd0);
    chk("midrst no_write", 64'(wq.size()), 64'd0);
    run_scan("after_rst", 16'h0700, 16'h0800, 32'd101);

    // Start held high for 50 cycles
    for (int i = 0; i < N; i++) mem[16'h0900 + i] = 32'h1000_0000 + i;
    model(16'h0900, 32'h2000_0000, ebn, ebh, ef);
    wq.delete();
    @(negedge clk);
    input_addr  = 16'h0900;
    result_addr = 16'h0A00;
    target      = 32'h2000_0000;
    start       = 1;
    ndone = 0;
    bad   = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (done !== (((c + 1) % (DLAT + 1)) == 0)) bad++;
    end
    start = 0;
    repeat (40) @(posedge clk);
    #1;
    scans = 0;
    for (int k = 0; k * (DLAT + 1) <= 49; k++) scans++;
    chk("hold pattern", 64'(bad), 64'd0);
    chk("hold ndone", 64'(ndone), 64'(50 / (DLAT + 1) +
        (((50 % (DLAT + 1)) == DLAT) ? 1 : 0)));
    chk("hold nonce", 64'(best_nonce), 64'(ebn));
    chk("hold hash", 64'(best_hash), 64'(ebh));
`ifdef GOLDEN_NONCE_WRITEBACK_EN
    chk("hold writes", 64'(wq.size()), 64'(2 * scans));
`else
    chk("hold writes", 64'(wq.size()), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
